// File: rtl/sobel_pkg.sv
// Shared widths and helpers for the Sobel gradient stage and the downstream
// square-root block, which imports the same MAG_W.
package sobel_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned GRAD_W  = PIX_W + 3;
  localparam int unsigned SQ_W    = 2 * GRAD_W - 2;
  localparam int unsigned MAG_W   = 16;
  localparam int unsigned MAG_MAX = (2 ** MAG_W) - 1;

  typedef logic [1:0] col_cnt_t;
  localparam col_cnt_t COL_FULL = 2'd3;

  typedef struct packed {
    logic [PIX_W-1:0] top;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] bot;
  } column_t;

  // |g| always fits in GRAD_W-1 bits because the kernel magnitude is bounded by 4*(2^PIX_W-1).
  function automatic logic [GRAD_W-2:0] grad_abs(input logic signed [GRAD_W-1:0] g);
    logic signed [GRAD_W-1:0] neg;
    neg = -g;
    return g[GRAD_W-1] ? neg[GRAD_W-2:0] : g[GRAD_W-2:0];
  endfunction

  function automatic logic [MAG_W-1:0] sat_mag(input logic [SQ_W:0] sum);
    logic [SQ_W:0] limit;
    limit = (SQ_W + 1)'(MAG_MAX);
    return (sum > limit) ? MAG_W'(MAG_MAX) : sum[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_kernel_calc.sv
// Combinational 3x3 Sobel kernel: three window columns in, signed Gx/Gy out.
// Kept free of any storage so a line-buffered front end can reuse it.
module sobel_kernel_calc
  import sobel_pkg::*;
(
  input  column_t                   c0,
  input  column_t                   c1,
  input  column_t                   c2,
  output logic signed [GRAD_W-1:0]  gx,
  output logic signed [GRAD_W-1:0]  gy
);

  function automatic logic [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b,
                                             input logic [PIX_W-1:0] c);
    return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
  endfunction

  logic [GRAD_W-1:0] x_pos;
  logic [GRAD_W-1:0] x_neg;
  logic [GRAD_W-1:0] y_pos;
  logic [GRAD_W-1:0] y_neg;

  // The centre pixel carries zero weight in both kernels.
  logic unused_centre;
  assign unused_centre = ^c1.mid;

  always_comb begin
    x_pos = wsum(c2.top, c2.mid, c2.bot);
    x_neg = wsum(c0.top, c0.mid, c0.bot);
    y_pos = wsum(c0.top, c1.top, c2.top);
    y_neg = wsum(c0.bot, c1.bot, c2.bot);
    gx    = $signed(x_pos - x_neg);
    gy    = $signed(y_pos - y_neg);
  end

endmodule

// File: rtl/sobel_grad_sq_pipe.sv
// Streaming Sobel stage: column window, Gx/Gy, squares, saturated sum.
// Whole pipeline stalls together on backpressure; bubbles are kept.
module sobel_grad_sq_pipe #(
  parameter int unsigned PIX_W = sobel_pkg::PIX_W,
  parameter int unsigned MAG_W = sobel_pkg::MAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_top,
  input  logic [PIX_W-1:0] in_mid,
  input  logic [PIX_W-1:0] in_bot,
  input  logic             in_sol,
  input  logic             in_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_mag,
  output logic             out_last
);
  import sobel_pkg::*;

  column_t  col_in;
  column_t  win0_q, win1_q, win2_q;
  col_cnt_t col_cnt_q, col_cnt_d;
  logic     win_valid_q, win_last_q;

  logic signed [GRAD_W-1:0] gx, gy;
  logic signed [GRAD_W-1:0] s1_gx_q, s1_gy_q;
  logic                     s1_valid_q, s1_last_q;

  logic [GRAD_W-2:0] abs_x, abs_y;
  logic [SQ_W-1:0]   sq_x, sq_y;
  logic [SQ_W-1:0]   s2_sq_x_q, s2_sq_y_q;
  logic              s2_valid_q, s2_last_q;

  logic [SQ_W:0]     sq_sum;
  logic [MAG_W-1:0]  s3_mag_q;
  logic              s3_valid_q, s3_last_q;

  logic advance, accept, win_done;

  assign col_in = {in_top, in_mid, in_bot};

  sobel_kernel_calc u_kernel (
    .c0 (win0_q),
    .c1 (win1_q),
    .c2 (win2_q),
    .gx (gx),
    .gy (gy)
  );

  always_comb begin
    advance = !s3_valid_q || out_ready;
    accept  = in_valid && advance;

    // in_sol restarts the count so stale columns never pair with a new line.
    if (in_sol) begin
      col_cnt_d = 2'd1;
    end else if (col_cnt_q == COL_FULL) begin
      col_cnt_d = COL_FULL;
    end else begin
      col_cnt_d = col_cnt_q + 2'd1;
    end
    win_done = (col_cnt_d == COL_FULL);

    abs_x  = grad_abs(s1_gx_q);
    abs_y  = grad_abs(s1_gy_q);
    sq_x   = SQ_W'(abs_x) * SQ_W'(abs_x);
    sq_y   = SQ_W'(abs_y) * SQ_W'(abs_y);
    sq_sum = (SQ_W + 1)'(s2_sq_x_q) + (SQ_W + 1)'(s2_sq_y_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win0_q      <= '0;
      win1_q      <= '0;
      win2_q      <= '0;
      col_cnt_q   <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      s1_gx_q     <= '0;
      s1_gy_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_sq_x_q   <= '0;
      s2_sq_y_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s3_mag_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        win0_q    <= win1_q;
        win1_q    <= win2_q;
        win2_q    <= col_in;
        col_cnt_q <= col_cnt_d;
      end
      win_valid_q <= accept && win_done;
      win_last_q  <= in_eol;

      s1_valid_q  <= win_valid_q;
      s1_last_q   <= win_last_q;
      s1_gx_q     <= gx;
      s1_gy_q     <= gy;

      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_sq_x_q   <= sq_x;
      s2_sq_y_q   <= sq_y;

      s3_valid_q  <= s2_valid_q;
      s3_last_q   <= s2_last_q;
      s3_mag_q    <= sat_mag(sq_sum);
    end
  end

  assign in_ready  = advance;
  assign out_valid = s3_valid_q;
  assign out_mag   = s3_mag_q;
  assign out_last  = s3_last_q;

endmodule

// File: tb/tb_sobel_grad_sq_pipe.sv
// Directed bench with a column-queue reference model and a per-cycle output checker.
module tb_sobel_grad_sq_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_top, in_mid, in_bot;
  logic        in_sol, in_eol;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mag;
  logic        out_last;

  sobel_grad_sq_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_top    (in_top),
    .in_mid    (in_mid),
    .in_bot    (in_bot),
    .in_sol    (in_sol),
    .in_eol    (in_eol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: columns of the current line, expected results and their timing.
  int lt[$], lm[$], lb[$];
  int exp_mag[$], exp_last[$], exp_cyc[$], exp_stall[$];
  int cyc = 0, stalls = 0, npop = 0;
  int last_mag = 0, last_last = 0;
  int hold_pending = 0, hold_mag = 0, hold_last = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Centre pixel has zero weight, so only eight pixels enter.
  function automatic int ref_mag(input int at, input int am, input int ab,
                                 input int bt, input int bb,
                                 input int ct, input int cm, input int cb);
    int gx, gy, s;
    gx = (ct + 2 * cm + cb) - (at + 2 * am + ab);
    gy = (at + 2 * bt + ct) - (ab + 2 * bb + cb);
    s  = gx * gx + gy * gy;
    return (s > 65535) ? 65535 : s;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        lt.delete(); lm.delete(); lb.delete();
        exp_mag.delete(); exp_last.delete(); exp_cyc.delete(); exp_stall.delete();
        hold_pending = 0;
      end else begin
        cyc++;
        if (hold_pending != 0) begin
          chk("hold_mag", int'(out_mag), hold_mag);
          chk("hold_last", int'(out_last), hold_last);
        end
        if (out_valid && !out_ready) begin
          chk("hold_in_ready", int'(in_ready), 0);
          stalls++;
          hold_pending = 1;
          hold_mag     = int'(out_mag);
          hold_last    = int'(out_last);
        end else begin
          hold_pending = 0;
        end
        if (out_valid && out_ready) begin
          if (exp_mag.size() == 0) begin
            chk("spurious_out", int'(out_valid), 0);
          end else begin
            int m, l, a, s;
            m = exp_mag.pop_front();
            l = exp_last.pop_front();
            a = exp_cyc.pop_front();
            s = exp_stall.pop_front();
            chk("mag", int'(out_mag), m);
            chk("last", int'(out_last), l);
            chk("latency", cyc - a, 4 + stalls - s);
            last_mag  = int'(out_mag);
            last_last = int'(out_last);
            npop++;
          end
        end
        if (in_valid && in_ready) begin
          if (in_sol) begin
            lt.delete(); lm.delete(); lb.delete();
          end
          lt.push_back(int'(in_top));
          lm.push_back(int'(in_mid));
          lb.push_back(int'(in_bot));
          if (lt.size() > 3) begin
            void'(lt.pop_front()); void'(lm.pop_front()); void'(lb.pop_front());
          end
          if (lt.size() == 3) begin
            exp_mag.push_back(ref_mag(lt[0], lm[0], lb[0], lt[1], lb[1], lt[2], lm[2], lb[2]));
            exp_last.push_back(int'(in_eol));
            exp_cyc.push_back(cyc);
            exp_stall.push_back(stalls);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int t, input int m, input int b, input bit sol, input bit eol);
    int tmo;
    in_valid = 1'b1;
    in_top   = 8'(t);
    in_mid   = 8'(m);
    in_bot   = 8'(b);
    in_sol   = sol;
    in_eol   = eol;
    tmo      = 0;
    @(negedge clk);
    while (!in_ready && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 100) chk("send_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_mag.size() != 0 && n < 60) begin
      idle(1);
      n++;
    end
    idle(1);
    chk("drain", exp_mag.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_top    = '0;
    in_mid    = '0;
    in_bot    = '0;
    in_sol    = 1'b0;
    in_eol    = 1'b0;
    out_ready = 1'b1;
    #12 rst = 1'b0;
    idle(1);

    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_mag", int'(out_mag), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    chk("model_flat", ref_mag(10, 10, 10, 10, 10, 20, 20, 20), 'h0640);
    chk("model_hedge", ref_mag(12, 10, 10, 12, 10, 12, 10, 10), 'h0040);
    chk("model_sat", ref_mag(0, 0, 0, 0, 0, 255, 255, 255), 'hFFFF);

    // Flat field with a vertical step.
    p = npop;
    send(10, 10, 10, 1, 0);
    send(10, 10, 10, 0, 0);
    send(20, 20, 20, 0, 0);
    drain();
    chk("flat_count", npop - p, 1);
    chk("flat_mag", last_mag, 'h0640);

    // Horizontal edge.
    p = npop;
    send(12, 10, 10, 1, 0);
    send(12, 10, 10, 0, 0);
    send(12, 10, 10, 0, 1);
    drain();
    chk("hedge_count", npop - p, 1);
    chk("hedge_mag", last_mag, 'h0040);
    chk("hedge_last", last_last, 1);

    // Saturation.
    p = npop;
    send(0, 0, 0, 1, 0);
    send(0, 0, 0, 0, 0);
    send(255, 255, 255, 0, 0);
    drain();
    chk("sat_count", npop - p, 1);
    chk("sat_mag", last_mag, 'hFFFF);

    // Five-column line, streamed back to back.
    p = npop;
    for (int k = 0; k < 5; k++) send(10 + 30 * k, 50 + 7 * k, 200 - 20 * k, k == 0, k == 4);
    drain();
    chk("line1_count", npop - p, 3);
    chk("line1_last", last_last, 1);

    // New line: first two columns must produce nothing.
    p = npop;
    for (int k = 0; k < 2; k++) send(255 - 30 * k, 3 * k * k, 100 + 20 * k, k == 0, 1'b0);
    idle(8);
    chk("line2_head_count", npop - p, 0);
    chk("line2_head_valid", int'(out_valid), 0);

    // Rest of the line with a 4-cycle backpressure window.
    fork
      begin
        for (int k = 2; k < 8; k++) send(255 - 30 * k, 3 * k * k, 100 + 20 * k, 1'b0, k == 7);
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(4);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("line2_count", npop - p, 6);
    chk("line2_last", last_last, 1);

    // Single-column line.
    p = npop;
    send(99, 50, 7, 1, 1);
    idle(8);
    chk("single_col_count", npop - p, 0);

    // Reset with two results in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(40 * k, 20 + k, 250 - 50 * k, k == 0, 1'b0);
    p = 0;
    while (!out_valid && p < 10) begin
      idle(1);
      p++;
    end
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_mag", int'(out_mag), 0);
    chk("async_rst_last", int'(out_last), 0);
    idle(2);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    idle(1);

    p = npop;
    send(1, 2, 3, 0, 0);
    send(4, 5, 6, 0, 0);
    idle(8);
    chk("post_rst_two_count", npop - p, 0);
    chk("post_rst_two_valid", int'(out_valid), 0);
    send(7, 8, 9, 0, 1);
    drain();
    chk("post_rst_count", npop - p, 1);
    chk("post_rst_mag", last_mag, 'h0280);
    chk("post_rst_last", last_last, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
